// File: rtl/dcache_repl_update_arb.sv
// Replacement-state update arbiter: round-robin hit ports into a coalescing FIFO; refills bypass it.
// Latency: miss -> plru_miss_o 1 cycle; hit into empty FIFO -> plru_hit_o 2 cycles.
// Backpressure: hit ports stall when FIFO full without a pop, or on flush/reset; misses never stall.
module dcache_repl_update_arb #(
    parameter int DCACHE_CL_IDX_WIDTH = 8,
    parameter int DCACHE_SET_ASSOC    = 4,
    parameter int NUM_PORTS           = 3,
    parameter int IDX_WIDTH           = DCACHE_CL_IDX_WIDTH,
    parameter int WAY_WIDTH           = $clog2(DCACHE_SET_ASSOC),
    parameter int DEPTH               = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NUM_PORTS-1:0]                hit_valid_i,
    input  logic [NUM_PORTS-1:0][IDX_WIDTH-1:0] hit_idx_i,
    input  logic [NUM_PORTS-1:0][WAY_WIDTH-1:0] hit_way_i,
    output logic [NUM_PORTS-1:0]                hit_ready_o,
    input  logic                                miss_valid_i,
    input  logic [IDX_WIDTH-1:0]                miss_idx_i,
    output logic                                plru_hit_o,
    output logic [IDX_WIDTH-1:0]                plru_hit_idx_o,
    output logic [WAY_WIDTH-1:0]                plru_hit_way_o,
    output logic                                plru_miss_o,
    output logic [IDX_WIDTH-1:0]                plru_miss_idx_o,
    output logic [$clog2(DEPTH):0]              occupancy_o
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic [WAY_WIDTH-1:0] way;
    } hit_ent_t;

    hit_ent_t             mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic                 plru_hit_q, plru_hit_d, plru_miss_q, plru_miss_d;
    logic [IDX_WIDTH-1:0] plru_hit_idx_q, plru_hit_idx_d, plru_miss_idx_q, plru_miss_idx_d;
    logic [WAY_WIDTH-1:0] plru_hit_way_q, plru_hit_way_d;

    logic [PW-1:0]        grant_port, cand;
    logic                 grant_vld;
    logic                 fifo_empty, fifo_full, head_blocked, pop, can_take, hs, coalesce, push;
    hit_ent_t             head_ent, tail_ent, acc_ent;

    assign tail_ptr     = wr_ptr_q - AW'(1);
    assign head_ent     = mem_q[rd_ptr_q];
    assign tail_ent     = mem_q[tail_ptr];
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CW'(DEPTH));
    // A refill to the head's set must reach the replacement state first.
    assign head_blocked = miss_valid_i && (miss_idx_i == head_ent.idx);
    assign pop          = !fifo_empty && !head_blocked && !flush_i && !rst_i;
    assign can_take     = !fifo_full || pop;
    assign hs           = grant_vld && can_take && !flush_i && !rst_i;
    // Compare against the newest entry while it is still queued, even if it pops this cycle.
    assign coalesce     = !fifo_empty && (tail_ent == acc_ent);
    assign push         = hs && !coalesce;

    // Round-robin pick: first valid port scanning upward from rr_q.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PW'((int'(rr_q) + k) % NUM_PORTS);
            if (!grant_vld && hit_valid_i[cand]) begin
                grant_vld  = 1'b1;
                grant_port = cand;
            end
        end
    end

    // Granted port's payload and per-port ready (ready never looks at idx/way).
    always_comb begin
        acc_ent.idx = hit_idx_i[grant_port];
        acc_ent.way = hit_way_i[grant_port];
        hit_ready_o = '0;
        if (hs) begin
            hit_ready_o[grant_port] = 1'b1;
        end
    end

    // Next-state for FIFO bookkeeping, arbitration pointer and registered update outputs.
    always_comb begin
        wr_ptr_d        = wr_ptr_q + AW'(push);
        rd_ptr_d        = rd_ptr_q + AW'(pop);
        count_d         = count_q + CW'(push) - CW'(pop);
        rr_d            = rr_q;
        plru_hit_d      = pop;
        plru_hit_idx_d  = plru_hit_idx_q;
        plru_hit_way_d  = plru_hit_way_q;
        plru_miss_d     = miss_valid_i && !flush_i;
        plru_miss_idx_d = plru_miss_idx_q;
        if (hs) begin
            rr_d = (int'(grant_port) == NUM_PORTS - 1) ? '0 : grant_port + PW'(1);
        end
        if (pop) begin
            plru_hit_idx_d = head_ent.idx;
            plru_hit_way_d = head_ent.way;
        end
        if (plru_miss_d) begin
            plru_miss_idx_d = miss_idx_i;
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rr_d     = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            rr_q            <= '0;
            plru_hit_q      <= 1'b0;
            plru_hit_idx_q  <= '0;
            plru_hit_way_q  <= '0;
            plru_miss_q     <= 1'b0;
            plru_miss_idx_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            rr_q            <= rr_d;
            plru_hit_q      <= plru_hit_d;
            plru_hit_idx_q  <= plru_hit_idx_d;
            plru_hit_way_q  <= plru_hit_way_d;
            plru_miss_q     <= plru_miss_d;
            plru_miss_idx_q <= plru_miss_idx_d;
        end
    end

    // FIFO storage; contents are only read while counted as occupied, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= acc_ent;
        end
    end

    assign plru_hit_o      = plru_hit_q;
    assign plru_hit_idx_o  = plru_hit_idx_q;
    assign plru_hit_way_o  = plru_hit_way_q;
    assign plru_miss_o     = plru_miss_q;
    assign plru_miss_idx_o = plru_miss_idx_q;
    assign occupancy_o     = count_q;
endmodule

// File: tb/tb_dcache_repl_update_arb.sv
// Testbench for dcache_repl_update_arb: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
// Inputs driven 1 time unit after the rising edge, outputs sampled 2 units after it.
module tb_dcache_repl_update_arb;
    localparam int NP = 3;
    localparam int IW = 8;
    localparam int WW = 2;
    localparam int DEPTH = 4;
    localparam int OW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [WW-1:0] way;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst, flush;
    logic [NP-1:0]          hv;
    logic [NP-1:0][IW-1:0]  hidx;
    logic [NP-1:0][WW-1:0]  hway;
    logic [NP-1:0]          hrdy;
    logic                   miss_v;
    logic [IW-1:0]          miss_idx;
    logic                   ph, pm;
    logic [IW-1:0]          ph_idx, pm_idx;
    logic [WW-1:0]          ph_way;
    logic [OW-1:0]          occ;

    always #5 clk = ~clk;

    dcache_repl_update_arb #(.NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .hit_valid_i(hv), .hit_idx_i(hidx), .hit_way_i(hway), .hit_ready_o(hrdy),
        .miss_valid_i(miss_v), .miss_idx_i(miss_idx),
        .plru_hit_o(ph), .plru_hit_idx_o(ph_idx), .plru_hit_way_o(ph_way),
        .plru_miss_o(pm), .plru_miss_idx_o(pm_idx), .occupancy_o(occ)
    );

    // Reference model state
    ent_t          mq[$];
    int            m_rr;
    logic          m_hit, m_miss;
    logic [IW-1:0] m_hit_idx, m_miss_idx;
    logic [WW-1:0] m_hit_way;

    int passed = 0, total = 0, fails = 0;
    int cyc = 0, hit_pulses = 0;
    int acc_log[$];
    int first_acc_cyc, first_hit_cyc, first_hit_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which port the rules say is ready given the current inputs and model state.
    function automatic logic [NP-1:0] model_ready();
        bit pop_ok, space;
        model_ready = '0;
        if (rst || flush) return model_ready;
        pop_ok = (mq.size() > 0) && !(miss_v && miss_idx == mq[0].idx);
        space  = (mq.size() < DEPTH) || pop_ok;
        if (!space) return model_ready;
        for (int k = 0; k < NP; k++) begin
            if (hv[(m_rr + k) % NP]) begin
                model_ready[(m_rr + k) % NP] = 1'b1;
                return model_ready;
            end
        end
    endfunction

    task automatic model_edge(input logic [NP-1:0] er);
        ent_t e;
        bit   popit, coal;
        int   p;
        if (rst) begin
            mq.delete(); m_rr = 0;
            m_hit = 0; m_hit_idx = '0; m_hit_way = '0; m_miss = 0; m_miss_idx = '0;
        end else if (flush) begin
            mq.delete(); m_rr = 0; m_hit = 0; m_miss = 0;
        end else begin
            popit = (mq.size() > 0) && !(miss_v && miss_idx == mq[0].idx);
            m_miss = miss_v;
            if (miss_v) m_miss_idx = miss_idx;
            m_hit = popit;
            if (popit) begin m_hit_idx = mq[0].idx; m_hit_way = mq[0].way; end
            p = -1;
            for (int i = 0; i < NP; i++) if (er[i] && hv[i]) p = i;
            coal = 0;
            e = '0;
            if (p >= 0) begin
                e.idx = hidx[p]; e.way = hway[p];
                coal = (mq.size() > 0) && (mq[$] == e);
                m_rr = (p + 1) % NP;
            end
            if (popit) void'(mq.pop_front());
            if (p >= 0 && !coal) mq.push_back(e);
        end
    endtask

    task automatic cycle();
        logic [NP-1:0] er;
        #1;
        er = model_ready();
        check("hit_ready_o", 32'(hrdy), 32'(er));
        check("plru_hit_o", 32'(ph), 32'(m_hit));
        check("plru_hit_idx_o", 32'(ph_idx), 32'(m_hit_idx));
        check("plru_hit_way_o", 32'(ph_way), 32'(m_hit_way));
        check("plru_miss_o", 32'(pm), 32'(m_miss));
        check("plru_miss_idx_o", 32'(pm_idx), 32'(m_miss_idx));
        check("occupancy_o", 32'(occ), 32'(mq.size()));
        if (ph) begin
            hit_pulses++;
            if (first_hit_cyc < 0) begin first_hit_cyc = cyc; first_hit_idx = int'(ph_idx); end
        end
        for (int i = 0; i < NP; i++) begin
            if (hv[i] && hrdy[i]) begin
                acc_log.push_back(i);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
        end
        @(posedge clk);
        model_edge(er);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        hv = '0; miss_v = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int exp_order[4];
        int p0, a0;
        exp_order = '{0, 1, 2, 0};
        rst = 1'b1; flush = 1'b0; hv = '1; miss_v = 1'b0; miss_idx = '0;
        hidx = '0; hway = '0;
        @(posedge clk); #1;
        model_edge('0);

        // Reset state with all ports requesting: nothing ready, outputs zero.
        cycle();
        first_acc_cyc = -1; first_hit_cyc = -1; first_hit_idx = -1; acc_log.delete();

        // Three ports continuously valid straight out of reset.
        rst = 1'b0;
        hidx[0] = 8'd5; hidx[1] = 8'd6; hidx[2] = 8'd7;
        hway[0] = 2'd1; hway[1] = 2'd2; hway[2] = 2'd3;
        repeat (4) cycle();
        check("grant_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("grant_order", (i < acc_log.size()) ? acc_log[i] : -1, exp_order[i]);
        check("first_hit_idx", first_hit_idx, 5);
        check("first_hit_latency", first_hit_cyc - first_acc_cyc, 2);
        idle(4);

        // Fill the FIFO while a repeated refill on the head's set blocks the pop.
        hv = 3'b010; hway[1] = 2'd0; miss_v = 1'b1; miss_idx = 8'd10;
        for (int i = 0; i < 4; i++) begin hidx[1] = IW'(10 + i); cycle(); end
        hidx[1] = 8'd14;
        #1;
        check("full_occupancy", 32'(occ), 32'd4);
        check("full_ready", 32'(hrdy), 32'd0);
        cycle();
        miss_v = 1'b0;
        #1;
        check("release_ready", 32'(hrdy), 32'b010);
        cycle();
        idle(6);

        // Refill and hit to the same set: miss first, hit one cycle later.
        hv = 3'b100; hidx[2] = 8'd9; hway[2] = 2'd0;
        cycle();
        hv = '0; miss_v = 1'b1; miss_idx = 8'd9;
        cycle();
        miss_v = 1'b0;
        #1;
        check("order_miss_strobe", 32'(pm), 32'd1);
        check("order_miss_idx", 32'(pm_idx), 32'd9);
        check("order_no_hit_yet", 32'(ph), 32'd0);
        cycle();
        #1;
        check("order_hit_strobe", 32'(ph), 32'd1);
        check("order_hit_idx", 32'(ph_idx), 32'd9);
        check("order_miss_done", 32'(pm), 32'd0);
        cycle();
        idle(3);

        // Back-to-back identical hits coalesce into one update.
        p0 = hit_pulses; a0 = acc_log.size();
        hv = 3'b001; hidx[0] = 8'd3; hway[0] = 2'd2;
        cycle();
        #1;
        check("coalesce_occ", 32'(occ), 32'd1);
        cycle();
        idle(4);
        check("coalesce_accepts", acc_log.size() - a0, 2);
        check("coalesce_pulses", hit_pulses - p0, 1);

        // Flush with three queued entries and a refill in the same cycle.
        hv = 3'b010; hway[1] = 2'd1; miss_v = 1'b1; miss_idx = 8'd20;
        for (int i = 0; i < 3; i++) begin hidx[1] = IW'(20 + i); cycle(); end
        flush = 1'b1; hv = 3'b111; hidx[0] = 8'd30; hidx[1] = 8'd31; hidx[2] = 8'd32;
        #1;
        check("flush_ready", 32'(hrdy), 32'd0);
        cycle();
        flush = 1'b0; miss_v = 1'b0;
        #1;
        check("flush_occ", 32'(occ), 32'd0);
        check("flush_no_hit", 32'(ph), 32'd0);
        check("flush_no_miss", 32'(pm), 32'd0);
        check("flush_rr_zero", 32'(hrdy), 32'b001);
        cycle();
        idle(4);

        // Reset in the middle of traffic with two entries queued.
        hv = 3'b010; hway[1] = 2'd3; miss_v = 1'b1; miss_idx = 8'd40;
        for (int i = 0; i < 2; i++) begin hidx[1] = IW'(40 + i); cycle(); end
        rst = 1'b1; hidx[1] = 8'd42;
        cycle();
        rst = 1'b0; hv = '0; miss_v = 1'b0;
        #1;
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_hit", 32'(ph), 32'd0);
        check("rst_hit_idx", 32'(ph_idx), 32'd0);
        check("rst_hit_way", 32'(ph_way), 32'd0);
        check("rst_miss", 32'(pm), 32'd0);
        check("rst_miss_idx", 32'(pm_idx), 32'd0);
        p0 = hit_pulses;
        idle(5);
        check("rst_no_stale_hit", hit_pulses - p0, 0);

        // Randomized traffic with narrow index ranges to provoke coalescing and blocking.
        for (int n = 0; n < 600; n++) begin
            hv = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                hidx[i] = IW'($urandom_range(0, 3));
                hway[i] = WW'($urandom_range(0, 3));
            end
            miss_v   = ($urandom_range(0, 1) == 1);
            miss_idx = IW'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dcache_repl_update_arb.md
DCACHE_REPL_UPDATE_ARB -- requirements
Module: dcache_repl_update_arb

Interface
REQ-001 SHALL provide parameter NUM_PORTS, default 3: number of hit-report ports (2..8).
REQ-002 SHALL provide parameter IDX_WIDTH, default DCACHE_CL_IDX_WIDTH: set-index width.
REQ-003 SHALL provide parameter WAY_WIDTH, default $clog2(DCACHE_SET_ASSOC): way-number width.
REQ-004 SHALL provide parameter DEPTH, default 4: hit FIFO entries (power of two, >=2).
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
REQ-006 SHALL provide the remaining ports:
- flush_i  in  1  discard all queued/pending updates
- hit_valid_i  in  NUM_PORTS  per-port hit report valid
- hit_idx_i  in  NUM_PORTS x IDX_WIDTH  per-port hit set index
- hit_way_i  in  NUM_PORTS x WAY_WIDTH  per-port hit way
- hit_ready_o  out  NUM_PORTS  per-port accept
- miss_valid_i  in  1  miss-return (refill) event, no backpressure
- miss_idx_i  in  IDX_WIDTH  refill set index
- plru_hit_o  out  1  replacement-state hit update strobe
- plru_hit_idx_o  out  IDX_WIDTH  hit update index
- plru_hit_way_o  out  WAY_WIDTH  hit update way
- plru_miss_o  out  1  replacement-state refill update strobe
- plru_miss_idx_o  out  IDX_WIDTH  refill update index
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO entry count

Function
REQ-007 Hit transfer SHALL complete when hit_valid_i[p] and hit_ready_o[p] are both high at a rising edge.
REQ-008 At most one port SHALL be granted per cycle; grant by round-robin starting at pointer rr_q, rr_q SHALL advance to (granted port + 1) mod NUM_PORTS only on a completed transfer.
REQ-009 hit_ready_o[p] SHALL be high only for the granted port, and only when FIFO not full (or a pop occurs the same cycle) and flush_i low; ready SHALL not depend on hit_idx_i/hit_way_i.
REQ-010 Accepted hit equal in idx and way to the most recently written entry still in the FIFO SHALL be coalesced: transfer completes, no entry written.
REQ-011 Miss path: miss_valid_i at cycle N SHALL produce plru_miss_o=1, plru_miss_idx_o=miss_idx_i at cycle N+1 (1-cycle latency, never dropped except by flush/reset).
REQ-012 Hit path: FIFO head SHALL load the registered hit outputs; a hit accepted into an empty FIFO at cycle N SHALL appear on plru_hit_o at N+2; plru_hit_o SHALL be a single-cycle pulse per entry.
REQ-013 Head pop SHALL be blocked in any cycle where miss_valid_i is high and miss_idx_i equals head idx; head SHALL pop the following eligible cycle (no hit update lost, miss wins ordering).
REQ-014 Hit and miss updates to different indices SHALL be emitted in the same cycle.
REQ-015 Simultaneous push and pop on a full FIFO SHALL be legal; occupancy unchanged.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; occupancy_o SHALL range 0..DEPTH.
REQ-017 flush_i high SHALL: deassert all hit_ready_o, drop that cycle's miss, empty the FIFO, reset rr_q to 0, and force plru_hit_o/plru_miss_o low in the next cycle.
REQ-018 Strobes SHALL be registered; idx/way outputs SHALL hold their last value when strobe low.

Reset
REQ-019 rst_i high at a rising edge SHALL set plru_hit_o=0, plru_miss_o=0, all idx/way outputs=0, occupancy_o=0, rr_q=0, FIFO pointers=0, regardless of in-flight traffic.
REQ-020 During reset hit_ready_o SHALL be all 0; first transfer possible the cycle after rst_i deasserts.

Verification
REQ-021 Ports 0,1,2 all valid continuously (idx 5,6,7, way 1,2,3) from empty -> grants in order 0,1,2,0; plru_hit_o pulses idx 5 first, two cycles after first accept.
REQ-022 Fill 4 entries with output blocked by repeated miss on head idx -> occupancy_o=4, all hit_ready_o=0; release -> one pop, ready returns same cycle.
REQ-023 Head idx 9 way 0 with miss_valid_i idx 9 same cycle -> plru_miss_o idx 9 next cycle, plru_hit_o idx 9 one cycle later, never both same cycle.
REQ-024 Port 0 reports idx 3 way 2 twice back-to-back -> two accepts, occupancy_o=1, single plru_hit_o pulse.
REQ-025 flush_i with occupancy 3 and miss_valid_i high -> next cycle occupancy_o=0, no strobes, rr_q=0.
REQ-026 rst_i asserted mid-stream with occupancy 2 -> next cycle all outputs 0, no stale hit emitted afterward.
